mc_main_ctrl: RTL and testbench

Multicycle main control FSM for the RV32I-subset core. It produces the aluop[1:0] encoding consumed by the ALU control decoder: 00 = add, 01 = sub/compare, 10 = R-type by funct, 11 = I-type by funct. It also sequences fetch, decode, execute, memory and writeback over shared memory with a req/ready handshake. On an illegal opcode or a memory timeout it halts with sticky error flags.

---
 rtl/mc_ctrl_pkg.sv | 44 ++++
 rtl/mc_mem_timeout.sv | 34 +++
 rtl/mc_main_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared encodings for the multicycle main control FSM.
// State, opcode, aluop and datapath mux-select constants.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;

  localparam logic [1:0] SRCB_RS2 = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;

endpackage

// File: rtl/mc_mem_timeout.sv
// mc_mem_timeout: wait counter for memory handshakes.
// expire fires on the last allowed cycle if ready is still low.
module mc_mem_timeout #(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic ready,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIM =
    CNT_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);

  logic [CNT_W-1:0] cnt;

  // count cycles spent waiting; any state change restarts the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && !ready) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign expire = (TIMEOUT_CYC != 0) && en
                && !ready && (cnt == LIM);

endmodule

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: multicycle main control FSM (RV32I subset).
// Define MC_CTRL_JAL_EN to decode JAL; otherwise it is illegal.
module mc_main_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       illegal,
  output logic       bus_err,
  output logic       halted,
  output logic [3:0] state_o
);

  state_t state, state_n;
  logic   to_en, to_clr, to_exp;
  logic   set_ill;

  assign to_en = (state == S_FETCH)
              || (state == S_MEM_RD)
              || (state == S_MEM_WR);
  assign to_clr  = (state_n != state);
  assign state_o = state;

  mc_mem_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) u_to (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (to_clr),
    .en    (to_en),
    .ready (mem_ready),
    .expire(to_exp)
  );

  // state register and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_n;
      if (set_ill) illegal <= 1'b1;
      if (to_exp)  bus_err <= 1'b1;
    end
  end

  // next state and Moore outputs (FETCH strobes gated by mem_ready)
  always_comb begin
    state_n       = state;
    set_ill       = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    aluop         = ALUOP_ADD;
    reg_write     = 1'b0;
    wb_sel        = WB_ALU;
    halted        = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_4;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)   state_n = S_DECODE;
        else if (to_exp) state_n = S_HALT;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        unique case (1'b1)
          (opcode == OP_R):      state_n = S_EXEC_R;
          (opcode == OP_I):      state_n = S_EXEC_I;
          (opcode == OP_LOAD),
          (opcode == OP_STORE):  state_n = S_MEM_ADDR;
          (opcode == OP_BRANCH): state_n = S_BRANCH;
`ifdef MC_CTRL_JAL_EN
          (opcode == OP_JAL):    state_n = S_JAL;
`endif
          default: begin
            state_n = S_HALT;
            set_ill = 1'b1;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        aluop     = ALUOP_R;
        state_n   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_I;
        state_n   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_ALU;
        state_n   = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        aluop     = ALUOP_ADD;
        state_n   = (opcode == OP_LOAD) ? S_MEM_RD
                                        : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready)   state_n = S_MEM_WB;
        else if (to_exp) state_n = S_HALT;
      end
      S_MEM_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_MEM;
        state_n   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        mem_we  = 1'b1;
        if (mem_ready)   state_n = S_FETCH;
        else if (to_exp) state_n = S_HALT;
      end
      S_BRANCH: begin
        alu_src_a     = SRCA_RS1;
        alu_src_b     = SRCB_RS2;
        aluop         = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 1'b1;
        state_n       = S_FETCH;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        state_n   = S_FETCH;
      end
`endif
      S_HALT: begin
        halted  = 1'b1;
        state_n = S_HALT;
      end
      default: begin
        state_n = S_HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// tb_mc_main_ctrl: scoreboard bench for mc_main_ctrl.
// Per-instruction cycle plans feed an expected-output queue.
module tb_mc_main_ctrl;

  localparam int TO = 4;

  localparam int K_R   = 0;
  localparam int K_I   = 1;
  localparam int K_LD  = 2;
  localparam int K_ST  = 3;
  localparam int K_BR  = 4;
  localparam int K_JAL = 5;
  localparam int K_ILL = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode = 7'd0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, i_or_d;
  logic       ir_write, pc_write;
  logic       pc_write_cond, pc_src;
  logic [1:0] alu_src_a, alu_src_b, aluop;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       illegal, bus_err, halted;
  logic [3:0] state_o;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_src;
    logic [1:0] asa;
    logic [1:0] asb;
    logic [1:0] aluop;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       illegal;
    logic       bus_err;
    logic       halted;
  } obs_t;

  typedef struct {
    logic       rdy;
    logic [6:0] op;
    obs_t       e;
  } cyc_t;

  cyc_t plan[$];
  obs_t sbq[$];
  int   total = 0;
  int   bad = 0;
  logic m_ill = 1'b0;
  logic m_be = 1'b0;
  obs_t mon_e;

  mc_main_ctrl #(
    .TIMEOUT_CYC(TO),
    .CNT_W      (5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .i_or_d       (i_or_d),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_src       (pc_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .aluop        (aluop),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .bus_err      (bus_err),
    .halted       (halted),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  function automatic obs_t exp_out(input logic [3:0] st,
                                   input logic rdy,
                                   input logic ill,
                                   input logic be);
    obs_t o;
    o = '0;
    o.st = st;
    o.illegal = ill;
    o.bus_err = be;
    case (st)
      4'd0: begin
        o.mem_req = 1'b1; o.asb = 2'b01;
        o.ir_write = rdy; o.pc_write = rdy;
      end
      4'd1: begin o.asa = 2'b10; o.asb = 2'b10; end
      4'd2: begin o.asa = 2'b01; o.aluop = 2'b10; end
      4'd3: begin
        o.asa = 2'b01; o.asb = 2'b10; o.aluop = 2'b11;
      end
      4'd4: o.reg_write = 1'b1;
      4'd5: begin o.asa = 2'b01; o.asb = 2'b10; end
      4'd6: begin o.mem_req = 1'b1; o.i_or_d = 1'b1; end
      4'd7: begin o.reg_write = 1'b1; o.wb_sel = 2'b01; end
      4'd8: begin
        o.mem_req = 1'b1; o.i_or_d = 1'b1; o.mem_we = 1'b1;
      end
      4'd9: begin
        o.asa = 2'b01; o.aluop = 2'b01;
        o.pc_write_cond = 1'b1; o.pc_src = 1'b1;
      end
      4'd10: begin
        o.reg_write = 1'b1; o.wb_sel = 2'b10;
        o.pc_write = 1'b1; o.pc_src = 1'b1;
      end
      4'd15: o.halted = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state_o;
    o.mem_req = mem_req;
    o.mem_we = mem_we;
    o.i_or_d = i_or_d;
    o.ir_write = ir_write;
    o.pc_write = pc_write;
    o.pc_write_cond = pc_write_cond;
    o.pc_src = pc_src;
    o.asa = alu_src_a;
    o.asb = alu_src_b;
    o.aluop = aluop;
    o.reg_write = reg_write;
    o.wb_sel = wb_sel;
    o.illegal = illegal;
    o.bus_err = bus_err;
    o.halted = halted;
    return o;
  endfunction

  task automatic check(input string nm, input obs_t a,
                       input obs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s t=%0t st got=%0d exp=%0d vec got=%h exp=%h",
               nm, $time, a.st, e.st, a, e);
    end
  endtask

  function automatic logic [6:0] junk();
    return 7'($urandom);
  endfunction

  function automatic logic [6:0] op_of(input int k);
    logic [6:0] o;
    case (k)
      K_R:     o = 7'b0110011;
      K_I:     o = 7'b0010011;
      K_LD:    o = 7'b0000011;
      K_ST:    o = 7'b0100011;
      K_BR:    o = 7'b1100011;
      K_JAL:   o = 7'b1101111;
      default: begin
        do o = junk();
        while (o == 7'b0110011 || o == 7'b0010011 ||
               o == 7'b0000011 || o == 7'b0100011 ||
               o == 7'b1100011 || o == 7'b1101111);
      end
    endcase
    return o;
  endfunction

  task automatic add(input logic [3:0] st, input logic rdy,
                     input logic [6:0] op);
    cyc_t c;
    c.rdy = rdy;
    c.op = op;
    c.e = exp_out(st, rdy, m_ill, m_be);
    plan.push_back(c);
  endtask

  task automatic halt_tail();
    repeat (3) add(4'd15, 1'($urandom), junk());
  endtask

  task automatic build(input int k, input logic [6:0] op,
                       input int wf, input int wm,
                       output bit h);
    logic [3:0] ms;
    h = 1'b0;
    for (int i = 0; i < TO; i++) begin
      add(4'd0, (i == wf), junk());
      if (i == wf) break;
    end
    if (wf >= TO) begin
      m_be = 1'b1; halt_tail(); h = 1'b1; return;
    end
    add(4'd1, 1'($urandom), op);
    case (k)
      K_R: begin
        add(4'd2, 1'($urandom), op); add(4'd4, 1'($urandom), op);
      end
      K_I: begin
        add(4'd3, 1'($urandom), op); add(4'd4, 1'($urandom), op);
      end
      K_LD, K_ST: begin
        add(4'd5, 1'($urandom), op);
        ms = (k == K_LD) ? 4'd6 : 4'd8;
        for (int i = 0; i < TO; i++) begin
          add(ms, (i == wm), op);
          if (i == wm) break;
        end
        if (wm >= TO) begin
          m_be = 1'b1; halt_tail(); h = 1'b1; return;
        end
        if (k == K_LD) add(4'd7, 1'($urandom), op);
      end
      K_BR: add(4'd9, 1'($urandom), op);
      K_JAL: begin
`ifdef MC_CTRL_JAL_EN
        add(4'd10, 1'($urandom), op);
`else
        m_ill = 1'b1; halt_tail(); h = 1'b1;
`endif
      end
      default: begin
        m_ill = 1'b1; halt_tail(); h = 1'b1;
      end
    endcase
  endtask

  task automatic play();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      mem_ready = c.rdy;
      opcode = c.op;
      sbq.push_back(c.e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [3:0] pre_st);
    int n;
    n = 0;
    while (sbq.size() > 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d required=0", sbq.size());
      sbq.delete();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    #2;
    check("pre_rst", sample(), exp_out(pre_st, 1'b0, m_ill, m_be));
    rst_n = 1'b0;
    #1;
    check("async_rst", sample(), exp_out(4'd0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ill = 1'b0;
    m_be = 1'b0;
  endtask

  task automatic run(input int k, input int wf, input int wm);
    bit h;
    build(k, op_of(k), wf, wm, h);
    play();
    if (h) do_reset(4'd15);
  endtask

  function automatic int rnd_wait();
    if ($urandom_range(0, 9) == 0)
      return TO + int'($urandom_range(0, 2));
    return int'($urandom_range(0, 3));
  endfunction

  // monitor: compare one expected bundle per cycle at negedge
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      check("cycle", sample(), mon_e);
    end
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset", sample(), exp_out(4'd0, 1'b0, 1'b0, 1'b0));
    rst_n = 1'b1;

    run(K_R, 0, 0);
    run(K_LD, 0, 3);
    run(K_BR, 1, 0);
    run(K_I, 2, 0);
    run(K_R, TO, 0);
    run(K_R, TO - 1, 0);
    build(K_ILL, 7'b1111111, 0, 0, mon_e.halted);
    play();
    do_reset(4'd15);
    run(K_JAL, 0, 0);
    run(K_ST, 0, 1);
    run(K_LD, 1, TO);

    add(4'd0, 1'b1, junk());
    add(4'd1, 1'b0, 7'b0100011);
    add(4'd5, 1'b0, 7'b0100011);
    add(4'd8, 1'b0, 7'b0100011);
    play();
    do_reset(4'd8);

    for (int n = 0; n < 250; n++) begin
      run(int'($urandom_range(0, 6)), rnd_wait(), rnd_wait());
    end

    repeat (2) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL final_queue left=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
